// File: rtl/hazard_pkg.sv
// Shared types for the hazard control unit: memory-freeze FSM states and hazard cause codes.
package hazard_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone
  } mem_state_e;

  localparam logic [2:0] HZ_NONE       = 3'd0;
  localparam logic [2:0] HZ_MEM_WAIT   = 3'd1;
  localparam logic [2:0] HZ_LOAD_USE   = 3'd2;
  localparam logic [2:0] HZ_BRANCH_USE = 3'd3;
  localparam logic [2:0] HZ_FLUSH      = 3'd4;

endpackage

// File: rtl/reg_match.sv
// Zero-exempt compare of one destination register against the ID-stage rs/rt operands.
module reg_match #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] dest,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic                  uses_rt,
  output logic                  match
);

  logic dest_nz;

  // $0 is hardwired to zero, so writes to it never create a dependency.
  assign dest_nz = (dest != '0);
  assign match   = dest_nz && ((dest == rs) || (uses_rt && (dest == rt)));

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline stall/flush controller: load-use and branch-operand stalls, control-transfer
// flush, multi-cycle data-memory freeze and a saturating stall-cycle counter.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W       = 5,
  parameter int unsigned MEM_STALL_CYCLES = 2,
  parameter int unsigned PERF_W           = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_ex_mem_read,
  input  logic                  id_ex_reg_write,
  input  logic [REG_ADDR_W-1:0] id_ex_write_reg,
  input  logic                  ex_mem_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_mem_write_reg,
  input  logic                  mem_access,
  input  logic [REG_ADDR_W-1:0] if_id_rs,
  input  logic [REG_ADDR_W-1:0] if_id_rt,
  input  logic                  if_id_uses_rt,
  input  logic                  id_branch,
  input  logic                  branch_taken,
  input  logic                  jump,
  output logic                  enable_pc,
  output logic                  enable_if_id,
  output logic                  enable_id_ex,
  output logic                  enable_ex_mem,
  output logic                  ctrl_bubble_n,
  output logic                  flush_if_id,
  output logic [2:0]            hazard_cause,
  output logic [PERF_W-1:0]     stall_count
);

  localparam int unsigned CntW    = (MEM_STALL_CYCLES > 1) ? $clog2(MEM_STALL_CYCLES + 1) : 1;
  localparam int unsigned CntLoad = (MEM_STALL_CYCLES > 1) ? MEM_STALL_CYCLES - 2 : 0;
  localparam bit          HasFreeze = (MEM_STALL_CYCLES > 0);
  localparam bit          MultiFreeze = (MEM_STALL_CYCLES > 1);

  mem_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PERF_W-1:0] stall_q;

  logic ex_match, mem_match;
  logic mem_wait, load_use, branch_use, redirect;

  reg_match #(.REG_ADDR_W(REG_ADDR_W)) u_ex_match (
    .dest    (id_ex_write_reg),
    .rs      (if_id_rs),
    .rt      (if_id_rt),
    .uses_rt (if_id_uses_rt),
    .match   (ex_match)
  );

  reg_match #(.REG_ADDR_W(REG_ADDR_W)) u_mem_match (
    .dest    (ex_mem_write_reg),
    .rs      (if_id_rs),
    .rt      (if_id_rt),
    .uses_rt (if_id_uses_rt),
    .match   (mem_match)
  );

  // The first frozen cycle is the IDLE cycle that sees the access, hence the -2 preload.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (mem_access && MultiFreeze) begin
          state_d = StWait;
          cnt_d   = CntW'(CntLoad);
        end else if (mem_access && HasFreeze) begin
          state_d = StDone;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign mem_wait   = (state_q == StWait) || ((state_q == StIdle) && mem_access && HasFreeze);
  assign load_use   = id_ex_mem_read && ex_match;
  assign branch_use = id_branch && ((id_ex_reg_write && ex_match) ||
                                    (ex_mem_mem_read && mem_match));
  assign redirect   = branch_taken || jump;

  always_comb begin
    enable_pc     = 1'b1;
    enable_if_id  = 1'b1;
    enable_id_ex  = 1'b1;
    enable_ex_mem = 1'b1;
    ctrl_bubble_n = 1'b1;
    flush_if_id   = 1'b0;
    hazard_cause  = HZ_NONE;
    if (!reset) begin
      if (mem_wait) begin
        enable_pc     = 1'b0;
        enable_if_id  = 1'b0;
        enable_id_ex  = 1'b0;
        enable_ex_mem = 1'b0;
        hazard_cause  = HZ_MEM_WAIT;
      end else if (load_use || branch_use) begin
        enable_pc     = 1'b0;
        enable_if_id  = 1'b0;
        ctrl_bubble_n = 1'b0;
        hazard_cause  = load_use ? HZ_LOAD_USE : HZ_BRANCH_USE;
      end else if (redirect) begin
        flush_if_id  = 1'b1;
        hazard_cause = HZ_FLUSH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!enable_pc && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign stall_count = stall_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed, table-driven bench for hazard_control_unit plus multi-cycle freeze/reset sequences.
module tb_hazard_control_unit;

  typedef struct packed {
    logic       lr;   // id_ex_mem_read
    logic       rw;   // id_ex_reg_write
    logic [4:0] wr;   // id_ex_write_reg
    logic       mr;   // ex_mem_mem_read
    logic [4:0] mwr;  // ex_mem_write_reg
    logic       ma;   // mem_access
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       br;
    logic       bt;
    logic       j;
  } in_t;

  // {enable_pc, enable_if_id, enable_id_ex, enable_ex_mem, ctrl_bubble_n, flush_if_id, cause}
  typedef logic [8:0] out_t;

  typedef struct {
    string name;
    in_t   in;
    out_t  exp;
  } vec_t;

  localparam out_t ONone = 9'b1_1_1_1_1_0_000;
  localparam out_t OLu   = 9'b0_0_1_1_0_0_010;
  localparam out_t OBu   = 9'b0_0_1_1_0_0_011;
  localparam out_t OFl   = 9'b1_1_1_1_1_1_100;
  localparam out_t OMw   = 9'b0_0_0_0_1_0_001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  in_t  cur = '0;

  logic        enable_pc, enable_if_id, enable_id_ex, enable_ex_mem, ctrl_bubble_n, flush_if_id;
  logic [2:0]  hazard_cause;
  logic [15:0] stall_count;

  logic        s_en_pc, s_en_ifid, s_en_idex, s_en_exmem, s_bub_n, s_flush;
  logic [2:0]  s_cause;
  logic [3:0]  s_stall_count;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int exp_sc  = 0;
  int exp_sc4 = 0;
  bit check4  = 1'b0;

  always #5 clk = ~clk;

  hazard_control_unit #(.REG_ADDR_W(5), .MEM_STALL_CYCLES(3), .PERF_W(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .id_ex_mem_read   (cur.lr),
    .id_ex_reg_write  (cur.rw),
    .id_ex_write_reg  (cur.wr),
    .ex_mem_mem_read  (cur.mr),
    .ex_mem_write_reg (cur.mwr),
    .mem_access       (cur.ma),
    .if_id_rs         (cur.rs),
    .if_id_rt         (cur.rt),
    .if_id_uses_rt    (cur.urt),
    .id_branch        (cur.br),
    .branch_taken     (cur.bt),
    .jump             (cur.j),
    .enable_pc        (enable_pc),
    .enable_if_id     (enable_if_id),
    .enable_id_ex     (enable_id_ex),
    .enable_ex_mem    (enable_ex_mem),
    .ctrl_bubble_n    (ctrl_bubble_n),
    .flush_if_id      (flush_if_id),
    .hazard_cause     (hazard_cause),
    .stall_count      (stall_count)
  );

  hazard_control_unit #(.REG_ADDR_W(5), .MEM_STALL_CYCLES(2), .PERF_W(4)) dut_s (
    .clk              (clk),
    .reset            (reset),
    .id_ex_mem_read   (cur.lr),
    .id_ex_reg_write  (cur.rw),
    .id_ex_write_reg  (cur.wr),
    .ex_mem_mem_read  (cur.mr),
    .ex_mem_write_reg (cur.mwr),
    .mem_access       (cur.ma),
    .if_id_rs         (cur.rs),
    .if_id_rt         (cur.rt),
    .if_id_uses_rt    (cur.urt),
    .id_branch        (cur.br),
    .branch_taken     (cur.bt),
    .jump             (cur.j),
    .enable_pc        (s_en_pc),
    .enable_if_id     (s_en_ifid),
    .enable_id_ex     (s_en_idex),
    .enable_ex_mem    (s_en_exmem),
    .ctrl_bubble_n    (s_bub_n),
    .flush_if_id      (s_flush),
    .hazard_cause     (s_cause),
    .stall_count      (s_stall_count)
  );

  function automatic in_t mk(input logic lr, input logic rw, input logic [4:0] wr,
                             input logic mr, input logic [4:0] mwr, input logic ma,
                             input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                             input logic br, input logic bt, input logic j);
    in_t v;
    v = '{lr: lr, rw: rw, wr: wr, mr: mr, mwr: mwr, ma: ma, rs: rs, rt: rt, urt: urt,
          br: br, bt: bt, j: j};
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    cmp_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle: drive, compare mid-cycle, then advance the stall-count model across the edge.
  task automatic step(input string name, input in_t v, input out_t e, input logic rst);
    cur   = v;
    reset = rst;
    @(negedge clk);
    chk({name, " outs"}, int'({enable_pc, enable_if_id, enable_id_ex, enable_ex_mem,
                               ctrl_bubble_n, flush_if_id, hazard_cause}), int'(e));
    chk({name, " stall_count"}, int'(stall_count), exp_sc);
    if (check4) chk({name, " stall_count4"}, int'(s_stall_count), exp_sc4);
    @(posedge clk);
    if (rst) begin
      exp_sc  = 0;
      exp_sc4 = 0;
    end else if (!e[8]) begin
      if (exp_sc < 65535) exp_sc++;
      if (exp_sc4 < 15) exp_sc4++;
    end
    #1;
  endtask

  vec_t vecs[$];
  in_t  q, lu8, lw9_br, ld9_mem_br, taken;

  initial begin
    q = '0;
    //                name                 lr rw  wr mr mwr ma rs rt urt br bt j
    vecs.push_back('{"lu_rs8",    mk(1, 1, 8, 0, 0, 0, 8, 0, 1, 0, 0, 0), OLu});
    vecs.push_back('{"lw_r0",     mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), ONone});
    vecs.push_back('{"rt_unused", mk(1, 1, 8, 0, 0, 0, 3, 8, 0, 0, 0, 0), ONone});
    vecs.push_back('{"lu_rt8",    mk(1, 1, 8, 0, 0, 0, 3, 8, 1, 0, 0, 0), OLu});
    vecs.push_back('{"alu_fwd",   mk(0, 1, 8, 0, 0, 0, 8, 0, 1, 0, 0, 0), ONone});
    vecs.push_back('{"bu_ex",     mk(0, 1, 8, 0, 0, 0, 8, 0, 1, 1, 0, 0), OBu});
    vecs.push_back('{"bu_mem",    mk(0, 0, 0, 1, 9, 0, 9, 0, 1, 1, 0, 0), OBu});
    vecs.push_back('{"mem_nobr",  mk(0, 0, 0, 1, 9, 0, 9, 0, 1, 0, 0, 0), ONone});
    vecs.push_back('{"br_taken",  mk(0, 0, 0, 0, 0, 0, 4, 5, 1, 1, 1, 0), OFl});
    vecs.push_back('{"jump",      mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), OFl});
    vecs.push_back('{"bu_taken",  mk(0, 1, 7, 0, 0, 0, 2, 7, 1, 1, 1, 0), OBu});
    vecs.push_back('{"lu_jump",   mk(1, 1, 6, 0, 0, 0, 6, 0, 0, 0, 0, 1), OLu});
    vecs.push_back('{"memwr_alu", mk(0, 0, 0, 0, 9, 0, 9, 0, 1, 1, 0, 0), ONone});
    vecs.push_back('{"br_r0",     mk(0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0), ONone});

    lu8        = mk(1, 1, 8, 0, 0, 0, 8, 0, 1, 0, 0, 0);
    lw9_br     = mk(1, 1, 9, 0, 0, 0, 9, 0, 1, 1, 1, 0);
    ld9_mem_br = mk(0, 0, 0, 1, 9, 0, 9, 0, 1, 1, 1, 0);
    taken      = mk(0, 0, 0, 0, 0, 0, 9, 0, 1, 1, 1, 0);

    // Reset held across two edges, then reset outputs forced despite hazardous inputs.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    begin
      in_t bad;
      bad    = lu8;
      bad.ma = 1'b1;
      step("reset_forced", bad, ONone, 1'b1);
    end

    foreach (vecs[i]) step(vecs[i].name, vecs[i].in, vecs[i].exp, 1'b0);

    // Load then branch on its result: load-use bubble, branch-use bubble, then flush.
    step("ldbr_c1", lw9_br, OLu, 1'b0);
    step("ldbr_c2", ld9_mem_br, OBu, 1'b0);
    step("ldbr_c3", taken, OFl, 1'b0);

    // Store held in MEM: two back-to-back accesses, each frozen 3 cycles then a DONE cycle.
    begin
      in_t st;
      st    = q;
      st.ma = 1'b1;
      for (int a = 0; a < 2; a++) begin
        for (int k = 0; k < 3; k++) step("sw_freeze", st, OMw, 1'b0);
        step("sw_done", st, ONone, 1'b0);
      end
    end
    step("idle_after_sw", q, ONone, 1'b0);

    // Freeze overlapping a load-use: cause is mem_wait, bubble lands in the DONE cycle.
    begin
      in_t ov;
      ov    = lu8;
      ov.ma = 1'b1;
      for (int k = 0; k < 3; k++) step("ovl_freeze", ov, OMw, 1'b0);
      step("ovl_done_lu", ov, OLu, 1'b0);
    end
    step("ovl_idle", q, ONone, 1'b0);

    // Reset while in WAIT returns to IDLE with the counter cleared.
    begin
      in_t st;
      st    = q;
      st.ma = 1'b1;
      step("rw_idle", st, OMw, 1'b0);
      step("rw_wait", st, OMw, 1'b0);
      step("rw_reset", st, ONone, 1'b1);
      step("rw_after", q, ONone, 1'b0);
    end

    // Twenty load-use stalls: 16-bit counter reaches 20, 4-bit counter sticks at 15.
    check4 = 1'b1;
    for (int k = 0; k < 20; k++) step("sat_lu", lu8, OLu, 1'b0);
    step("sat_end", q, ONone, 1'b0);
    chk("sat_final4", int'(s_stall_count), 15);
    chk("sat_final16", int'(stall_count), 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
